cram_writer: RTL and testbench

- Write-side front end for the 256x16 colour RAM (CRAM); the video output stage reads the same RAM.
- Merges three sources of palette writes:
  - Z80 byte writes, assembled into 16-bit words.
  - DMA word writes.
  - A hardware fill engine.
- Queues merged writes in a small FIFO and drains them to the CRAM write port as cram_we/cram_addr_in/cram_data_in, one word per cycle whenever the port is free.
- Gives the palette a single CRAM write port, with no CPU stalls.

---
 rtl/cram_writer_pkg.sv | 24 ++
 rtl/cram_wr_fifo.sv | 55 +++++
 rtl/cram_writer.sv | 165 ++++++++++++++++
 tb/tb_cram_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_writer_pkg.sv
// Shared video definitions for the colour RAM write path.
package cram_writer_pkg;

   localparam int CRAM_AW  = 8;
   localparam int CRAM_DW  = 16;
   localparam int VDAC_BIT = 15;

   typedef struct packed {
      logic [CRAM_AW-1:0] addr;
      logic [CRAM_DW-1:0] data;
   } cram_wr_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   // Joins an assembled high byte with the held low byte.
   function automatic logic [CRAM_DW-1:0] cram_word(input logic [CRAM_DW/2-1:0] hi,
                                                    input logic [CRAM_DW/2-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/cram_wr_fifo.sv
// Small synchronous FIFO of CRAM writes. A push while full is taken when a
// pop happens in the same cycle, so a full FIFO still streams at full rate.
module cram_wr_fifo
   import cram_writer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  cram_wr_t         push_data,
   input  logic             pop,
   output cram_wr_t         pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   cram_wr_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cram_writer.sv
// CRAM write front end: assembles Z80 bytes, merges DMA and fill-engine
// words into one FIFO, and drains it to the single CRAM write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no fill running; DMA may push
// ST_FILL | fill engine pushing {ptr, word} whenever the CPU is quiet
module cram_writer
   import cram_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = CRAM_AW,
   parameter int DATA_W     = CRAM_DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_wr,
   input  logic [ADDR_W:0]   cpu_addr,
   input  logic [7:0]        cpu_data,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_data,
   output logic              dma_ack,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W-1:0] fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              overflow,
   input  logic              ovf_clr,
   input  logic              cram_busy,
   output logic              cram_we,
   output logic [ADDR_W-1:0] cram_addr_in,
   output logic [DATA_W-1:0] cram_data_in
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              fill_go;

   logic [7:0]        hold_q;
   logic              cpu_push_req;
   logic              dma_go;
   logic              pop;
   logic              can_push;
   logic              push;
   cram_wr_t          push_data;
   cram_wr_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   assign cpu_push_req = cpu_wr & cpu_addr[0];
   assign pop          = ~fifo_empty & ~cram_busy;
   assign can_push     = ~fifo_full | pop;
   // DMA yields to the CPU and never interleaves with a running fill.
   assign dma_go       = dma_req & ~cpu_push_req & (state_q == ST_IDLE) & can_push;
   assign dma_ack      = dma_go;
   assign push         = cpu_push_req | dma_go | fill_go;
   assign busy         = (state_q == ST_FILL) | (fifo_count != '0) | cram_we;

   // Fixed-priority push source select: CPU, then DMA, then fill.
   always_comb begin
      push_data = '0;
      if (cpu_push_req) begin
         push_data.addr = cpu_addr[ADDR_W:1];
         push_data.data = cram_word(cpu_data, hold_q);
      end else if (dma_go) begin
         push_data.addr = dma_addr;
         push_data.data = dma_data;
      end else begin
         push_data.addr = ptr_q;
         push_data.data = word_q;
      end
   end

   // Fill FSM next state; the fill only advances on cycles the FIFO takes its word.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      word_d  = word_q;
      fill_go = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fill_start) begin
               state_d = ST_FILL;
               ptr_d   = fill_base;
               rem_d   = fill_len;
               word_d  = fill_data;
            end
         end
         ST_FILL: begin
            if (!cpu_push_req && can_push) begin
               fill_go = 1'b1;
               ptr_d   = ptr_q + ADDR_W'(1);
               rem_d   = rem_q - ADDR_W'(1);
               if (rem_q == '0) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fill FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         word_q  <= word_d;
      end
   end

   // Low-byte holding register and sticky overflow (a new drop beats a clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (cpu_wr && !cpu_addr[0]) hold_q <= cpu_data;
         if (cpu_push_req && !can_push) overflow <= 1'b1;
         else if (ovf_clr)              overflow <= 1'b0;
      end
   end

   cram_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Registered CRAM port; address/data hold between writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cram_we      <= 1'b0;
         cram_addr_in <= '0;
         cram_data_in <= '0;
      end else begin
         cram_we <= pop;
         if (pop) begin
            cram_addr_in <= head.addr;
            cram_data_in <= head.data;
         end
      end
   end

endmodule

// File: tb/tb_cram_writer.sv
// Directed bench for cram_writer with a queue-based scoreboard.
module tb_cram_writer;
   import cram_writer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_wr;
   logic [8:0]  cpu_addr;
   logic [7:0]  cpu_data;
   logic        dma_req;
   logic [7:0]  dma_addr;
   logic [15:0] dma_data;
   logic        dma_ack;
   logic        fill_start;
   logic [7:0]  fill_base;
   logic [7:0]  fill_len;
   logic [15:0] fill_data;
   logic        busy;
   logic        overflow;
   logic        ovf_clr;
   logic        cram_busy;
   logic        cram_we;
   logic [7:0]  cram_addr_in;
   logic [15:0] cram_data_in;

   int       checks   = 0;
   int       failures = 0;
   cram_wr_t exp_q[$];

   always #5 clk = ~clk;

   cram_writer #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_wr       (cpu_wr),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .dma_req      (dma_req),
      .dma_addr     (dma_addr),
      .dma_data     (dma_data),
      .dma_ack      (dma_ack),
      .fill_start   (fill_start),
      .fill_base    (fill_base),
      .fill_len     (fill_len),
      .fill_data    (fill_data),
      .busy         (busy),
      .overflow     (overflow),
      .ovf_clr      (ovf_clr),
      .cram_busy    (cram_busy),
      .cram_we      (cram_we),
      .cram_addr_in (cram_addr_in),
      .cram_data_in (cram_data_in)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
      cram_wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_data = d;
      cpu_wr   = 1'b1;
      @(negedge clk);
      cpu_wr   = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_idle"}, busy, 1'b0);
   endtask

   // Monitor: every CRAM write must match the oldest expected write.
   always @(negedge clk) begin
      cram_wr_t e;
      if (rst_n && cram_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     cram_addr_in, cram_data_in);
         end else begin
            e = exp_q.pop_front();
            check("cram_write", {8'h0, cram_addr_in, cram_data_in}, {8'h0, e.addr, e.data});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] wrap_a [4];
      int acks;
      int n;
      int we_seen;

      rst_n = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
      dma_req = 1'b0; dma_addr = '0; dma_data = '0;
      fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_data = '0;
      ovf_clr = 1'b0; cram_busy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cram_we", cram_we, 1'b0);
      check("rst_addr", cram_addr_in, 8'h00);
      check("rst_data", cram_data_in, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_dma_ack", dma_ack, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // CPU byte assembly and two-cycle latency
      cpu_write(9'h00A, 8'h34);
      repeat (2) @(negedge clk);
      check("low_byte_no_write", cram_we, 1'b0);
      expect_wr(8'h05, 16'h9234);
      cpu_write(9'h00B, 8'h92);
      check("cpu_lat_n1", cram_we, 1'b0);
      @(negedge clk);
      check("cpu_lat_n2", cram_we, 1'b1);
      drain("t1");

      // DMA stalls on a full FIFO
      cram_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dma_addr = 8'h10 + 8'(i);
         dma_data = 16'hD000 + 16'(i);
         dma_req  = 1'b1;
         #1;
         check("dma_ack_free", dma_ack, 1'b1);
         if (dma_ack) expect_wr(dma_addr, dma_data);
         @(negedge clk);
         dma_req = 1'b0;
      end
      dma_addr = 8'h14;
      dma_data = 16'hD004;
      dma_req  = 1'b1;
      acks = 0;
      repeat (5) begin
         #1;
         if (dma_ack) acks++;
         @(negedge clk);
      end
      check("dma_full_no_ack", acks, 0);
      cram_busy = 1'b0;
      #1;
      check("dma_ack_on_pop", dma_ack, 1'b1);
      if (dma_ack) expect_wr(8'h14, 16'hD004);
      @(negedge clk);
      dma_req = 1'b0;
      drain("t2");

      // CPU overflow drops the word and sets the sticky flag
      cram_busy = 1'b1;
      cpu_write(9'h040, 8'h11);
      for (int i = 0; i < 4; i++) begin
         expect_wr(8'h20 + 8'(i), {8'hA0 + 8'(i), 8'h11});
         cpu_write({8'h20 + 8'(i), 1'b1}, 8'hA0 + 8'(i));
      end
      check("ovf_before_drop", overflow, 1'b0);
      cpu_write({8'h30, 1'b1}, 8'hEE);
      check("ovf_set", overflow, 1'b1);
      cram_busy = 1'b0;
      drain("t3");
      check("ovf_sticky", overflow, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_cleared", overflow, 1'b0);

      // Wrapping fill FE, FF, 00, 01
      wrap_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 4; i++) expect_wr(wrap_a[i], 16'h7FFF);
      fill_base = 8'hFE; fill_len = 8'd3; fill_data = 16'h7FFF; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      we_seen = 0;
      n = 0;
      while (we_seen < 4 && n < 50) begin
         @(negedge clk);
         n++;
         if (cram_we) we_seen++;
      end
      check("fill_wrap_count", we_seen, 4);
      check("busy_at_last_we", busy, 1'b1);
      @(negedge clk);
      check("busy_after_last_we", busy, 1'b0);

      // 256-entry fill interrupted by one CPU word; DMA waits for the fill
      cpu_write(9'h020, 8'hCD);
      for (int i = 0; i < 4; i++) expect_wr(8'(i), 16'h1234);
      expect_wr(8'h10, 16'hABCD);
      for (int i = 4; i < 256; i++) expect_wr(8'(i), 16'h1234);
      fill_base = 8'h00; fill_len = 8'hFF; fill_data = 16'h1234; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      repeat (2) @(negedge clk);
      fill_base = 8'h80; fill_data = 16'h0BAD; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      @(negedge clk);
      cpu_write(9'h021, 8'hAB);
      dma_addr = 8'h77;
      dma_data = 16'hBEEF;
      dma_req  = 1'b1;
      n = 0;
      #1;
      while (!dma_ack && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("dma_held_during_fill", n, 252);
      if (dma_ack) expect_wr(8'h77, 16'hBEEF);
      @(negedge clk);
      dma_req = 1'b0;
      drain("t5");

      // Reset mid-fill flushes queued words
      cram_busy = 1'b1;
      fill_base = 8'h20; fill_len = 8'd10; fill_data = 16'h0F0F; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("rst_mid_cram_we", cram_we, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_addr", cram_addr_in, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cram_busy = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_idle", busy, 1'b0);
      expect_wr(8'h03, 16'h5500);
      cpu_write(9'h007, 8'h55);
      expect_wr(8'h40, 16'h8001);
      expect_wr(8'h41, 16'h8001);
      fill_base = 8'h40; fill_len = 8'd1; fill_data = 16'h8001; fill_start = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      drain("t6");

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
